tile_collector: RTL and testbench

TILE_COLLECTOR -- requirements
Module: tile_collector

---
 rtl/flex_pkg.sv | 22 ++
 rtl/tile_addr_gen.sv | 61 ++++++
 rtl/tile_collector.sv | 117 +++++++++++
 tb/tb_tile_collector.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_pkg.sv
// Shared types and helpers for the tile collector datapath.
package flex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } tc_state_e;

    typedef enum logic {
        DRAIN_COL = 1'b0,
        DRAIN_ROW = 1'b1
    } drain_mode_e;

    // Beats needed to drain an m x k tile with the given number of lanes.
    function automatic int tile_beats(input int m, input int k, input int lanes);
        return (m * k) / lanes;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Purpose: row/col walk over the result tile in column- or row-major order.
// Latency: counters update on the edge that accepts a beat; last is combinational.
// Backpressure: counters hold whenever adv is low.
module tile_addr_gen
    import flex_pkg::*;
#(
    parameter int M     = 4,
    parameter int K     = 4,
    parameter int LANES = 2,
    parameter int RW    = $clog2(M) + 1,
    parameter int CW    = $clog2(K) + 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          clr,
    input  logic          adv,
    input  drain_mode_e   mode,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] M_R        = RW'(M);
    localparam logic [RW-1:0] LANES_R    = RW'(LANES);
    localparam logic [RW-1:0] R_LAST_COL = RW'(M - LANES);
    localparam logic [RW-1:0] R_LAST_ROW = RW'(M - 1);
    localparam logic [CW-1:0] K_C        = CW'(K);
    localparam logic [CW-1:0] LANES_C    = CW'(LANES);
    localparam logic [CW-1:0] C_LAST_COL = CW'(K - 1);
    localparam logic [CW-1:0] C_LAST_ROW = CW'(K - LANES);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (mode == DRAIN_COL) begin
                if (row + LANES_R == M_R) begin
                    row <= '0;
                    col <= col + CW'(1);
                end else begin
                    row <= row + LANES_R;
                end
            end else begin
                if (col + LANES_C == K_C) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + LANES_C;
                end
            end
        end
    end

    assign last = (mode == DRAIN_COL) ? ((row == R_LAST_COL) && (col == C_LAST_COL))
                                      : ((row == R_LAST_ROW) && (col == C_LAST_ROW));

endmodule

// File: rtl/tile_collector.sv
// Purpose: waits for dispatch and array completion, then drains the result tile LANES datums per beat.
// Latency: first push one cycle after both completion flags are seen; one beat per cycle thereafter.
// Backpressure: fifo_full stalls the drain in place; push is simply withheld.
module tile_collector
    import flex_pkg::*;
#(
    parameter int M     = 4,
    parameter int K     = 4,
    parameter int LANES = 2,
    parameter int DW    = 32
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start,
    input  logic                      mode,
    input  logic                      done_dispatch,
    input  logic                      done,
    input  logic                      err,
    input  logic [M*K-1:0][DW-1:0]    res,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [LANES*DW-1:0]       fifo_data,
    output logic                      sys_comp_done,
    output logic                      sys_comp_err,
    output logic                      tile_done,
    output logic                      busy
);

    localparam int RW = $clog2(M) + 1;
    localparam int CW = $clog2(K) + 1;
    localparam int IW = (M * K > 1) ? $clog2(M * K) : 1;

    if ((M % LANES) != 0 || (K % LANES) != 0 ||
        tile_beats(M, K, LANES) * LANES != M * K) begin : g_bad_lanes
        $error("tile_collector: LANES must divide both M and K");
    end

    tc_state_e   state_q, state_d;
    drain_mode_e mode_q;
    logic        start_acc;
    logic        err_any;
    logic        last_beat;
    logic [RW-1:0] row;
    logic [CW-1:0] col;

    assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    // Raw err is included so an error coinciding with the last beat still lands in ERR.
    assign err_any   = err || sys_comp_err;
    assign fifo_push = (state_q == ST_DRAIN) && !fifo_full;
    assign tile_done = (state_q == ST_DONE);
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= ST_IDLE;
            mode_q        <= DRAIN_COL;
            sys_comp_done <= 1'b0;
            sys_comp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                mode_q        <= drain_mode_e'(mode);
                sys_comp_done <= 1'b0;
                sys_comp_err  <= 1'b0;
            end else begin
                sys_comp_done <= sys_comp_done || done;
                sys_comp_err  <= sys_comp_err || err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (err_any)                             state_d = ST_ERR;
                else if (done_dispatch && sys_comp_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (err_any)                     state_d = ST_ERR;
                else if (fifo_push && last_beat) state_d = ST_DONE;
            end
            ST_DONE, ST_ERR: begin
                if (start) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    tile_addr_gen #(
        .M     (M),
        .K     (K),
        .LANES (LANES),
        .RW    (RW),
        .CW    (CW)
    ) u_addr (
        .clk  (clk),
        .nrst (nrst),
        .clr  (start_acc),
        .adv  (fifo_push),
        .mode (mode_q),
        .row  (row),
        .col  (col),
        .last (last_beat)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [IW-1:0] idx;
        assign idx = (mode_q == DRAIN_COL) ? IW'((int'(row) + i) * K + int'(col))
                                           : IW'(int'(row) * K + int'(col) + i);
        assign fifo_data[i*DW +: DW] = fifo_push ? res[idx] : '0;
    end

endmodule

// File: tb/tb_tile_collector.sv
// Bench for tile_collector: directed scenarios plus randomized tiles against a queue-based drain-order model.
module tb_tile_collector;

    localparam int M     = 4;
    localparam int K     = 4;
    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int BW    = LANES * DW;
    localparam int BEATS = M * K / LANES;

    logic                   clk = 1'b0;
    logic                   nrst;
    logic                   start;
    logic                   mode;
    logic                   done_dispatch;
    logic                   done;
    logic                   err;
    logic [M*K-1:0][DW-1:0] res;
    logic                   fifo_full;
    logic                   fifo_push;
    logic [BW-1:0]          fifo_data;
    logic                   sys_comp_done;
    logic                   sys_comp_err;
    logic                   tile_done;
    logic                   busy;

    tile_collector #(.M(M), .K(K), .LANES(LANES), .DW(DW)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .mode          (mode),
        .done_dispatch (done_dispatch),
        .done          (done),
        .err           (err),
        .res           (res),
        .fifo_full     (fifo_full),
        .fifo_push     (fifo_push),
        .fifo_data     (fifo_data),
        .sys_comp_done (sys_comp_done),
        .sys_comp_err  (sys_comp_err),
        .tile_done     (tile_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    bit            bp_random = 1'b0;
    logic [BW-1:0] got[$];
    int            got_cyc[$];
    logic [BW-1:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Output monitor: collect pushes, and enforce flow-control/zeroing rules every cycle.
    always @(negedge clk) begin
        if (fifo_push === 1'b1) begin
            got.push_back(fifo_data);
            got_cyc.push_back(cyc);
            chk("push_while_full", BW'(fifo_full), '0);
        end else begin
            chk("data_zero_no_push", fifo_data, '0);
        end
    end

    // Reference drain order, straight from the tile indexing rules.
    task automatic fill_exp(input logic md);
        logic [BW-1:0] beat;
        exp_q.delete();
        if (md == 1'b0) begin
            for (int c = 0; c < K; c++)
                for (int r = 0; r < M; r += LANES) begin
                    for (int i = 0; i < LANES; i++) beat[i*DW +: DW] = res[(r+i)*K + c];
                    exp_q.push_back(beat);
                end
        end else begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < K; c += LANES) begin
                    for (int i = 0; i < LANES; i++) beat[i*DW +: DW] = res[r*K + c + i];
                    exp_q.push_back(beat);
                end
        end
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_count"}, BW'(got.size()), BW'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic clear_got();
        got.delete();
        got_cyc.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bp_random) fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_start(input logic md);
        start = 1'b1;
        mode  = md;
        step();
        start = 1'b0;
        mode  = ~md;
    endtask

    task automatic wait_done(input string tag, input int budget, output int td_cyc);
        int n = 0;
        while (tile_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        td_cyc = cyc;
        chk({tag, "_tile_done"}, BW'(tile_done), BW'(1));
    endtask

    task automatic count_pushes_to(input int target, input string tag);
        int n = 0;
        int guard = 0;
        while (n < target && guard < 100) begin
            @(negedge clk);
            if (fifo_push === 1'b1) n++;
            guard++;
        end
        chk({tag, "_reach_beat"}, BW'(n), BW'(target));
        #1;
    endtask

    task automatic set_ramp();
        for (int n = 0; n < M*K; n++) res[n] = DW'(n);
    endtask

    task automatic run_basic(input logic md, input string tag);
        int td;
        clear_got();
        do_start(md);
        chk({tag, "_busy"}, BW'(busy), BW'(1));
        done = 1'b1;
        done_dispatch = 1'b1;
        step();
        done = 1'b0;
        wait_done(tag, 100, td);
        fill_exp(md);
        cmp_seq(tag);
        if (got.size() == BEATS) begin
            chk({tag, "_back_to_back"}, BW'(got_cyc[BEATS-1] - got_cyc[0]), BW'(BEATS - 1));
            chk({tag, "_done_cycle"}, BW'(td), BW'(got_cyc[BEATS-1] + 1));
        end
        chk({tag, "_busy_after"}, BW'(busy), '0);
        chk({tag, "_comp_done"}, BW'(sys_comp_done), BW'(1));
        done_dispatch = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int td;
        int d1, d2, j;
        logic md;

        nrst = 1'b0; start = 1'b0; mode = 1'b0; done_dispatch = 1'b0;
        done = 1'b0; err = 1'b0; fifo_full = 1'b0;
        set_ramp();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push", BW'(fifo_push), '0);
        chk("rst_data", fifo_data, '0);
        chk("rst_tile_done", BW'(tile_done), '0);
        chk("rst_busy", BW'(busy), '0);
        chk("rst_comp_done", BW'(sys_comp_done), '0);
        chk("rst_comp_err", BW'(sys_comp_err), '0);
        nrst = 1'b1;
        step();

        // Basic column-major and row-major drains.
        run_basic(1'b0, "colmaj");
        run_basic(1'b1, "rowmaj");

        // Backpressure on the 3rd beat for 3 cycles.
        clear_got();
        do_start(1'b0);
        done = 1'b1; done_dispatch = 1'b1;
        step();
        begin
            int g = 0;
            while (got.size() < 2 && g < 50) begin step(); g++; end
        end
        fifo_full = 1'b1;
        repeat (3) step();
        fifo_full = 1'b0;
        wait_done("stall", 100, td);
        fill_exp(1'b0);
        cmp_seq("stall");
        if (got.size() == BEATS) begin
            chk("stall_gap", BW'(got_cyc[2] - got_cyc[1]), BW'(4));
            chk("stall_span", BW'(got_cyc[BEATS-1] - got_cyc[0]), BW'(BEATS - 1 + 3));
        end
        done = 1'b0; done_dispatch = 1'b0;

        // Error right after beat 4 aborts the drain.
        clear_got();
        do_start(1'b0);
        done = 1'b1; done_dispatch = 1'b1;
        step();
        count_pushes_to(4, "err");
        err = 1'b1;
        @(posedge clk);
        #1;
        err = 1'b0;
        chk("err_sticky", BW'(sys_comp_err), BW'(1));
        repeat (3) step();
        chk("err_push_count", BW'(got.size()), BW'(4));
        chk("err_busy", BW'(busy), '0);
        chk("err_tile_done", BW'(tile_done), '0);
        done = 1'b0; done_dispatch = 1'b0;
        do_start(1'b0);
        chk("err_restart_clear", BW'(sys_comp_err), '0);
        chk("err_restart_busy", BW'(busy), BW'(1));
        clear_got();
        done = 1'b1; done_dispatch = 1'b1;
        step();
        done = 1'b0;
        wait_done("err_recover", 100, td);
        fill_exp(1'b0);
        cmp_seq("err_recover");
        done_dispatch = 1'b0;

        // done arrives well before done_dispatch.
        clear_got();
        do_start(1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (4) step();
        chk("early_comp_done", BW'(sys_comp_done), BW'(1));
        chk("early_no_push", BW'(got.size()), '0);
        done_dispatch = 1'b1;
        d1 = cyc;
        wait_done("early", 100, td);
        if (got.size() > 0) chk("early_first_push", BW'(got_cyc[0]), BW'(d1 + 1));
        fill_exp(1'b1);
        cmp_seq("early");
        done_dispatch = 1'b0;

        // Reset in the middle of a drain.
        clear_got();
        do_start(1'b0);
        done = 1'b1; done_dispatch = 1'b1;
        step();
        count_pushes_to(3, "rst_mid");
        nrst = 1'b0;
        #1;
        chk("rst_mid_push", BW'(fifo_push), '0);
        chk("rst_mid_data", fifo_data, '0);
        chk("rst_mid_busy", BW'(busy), '0);
        chk("rst_mid_comp_done", BW'(sys_comp_done), '0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (4) step();
        chk("rst_mid_no_push", BW'(got.size()), BW'(3));
        chk("rst_mid_idle", BW'(busy), '0);
        clear_got();
        do_start(1'b0);
        wait_done("rst_restart", 100, td);
        fill_exp(1'b0);
        cmp_seq("rst_restart");
        done = 1'b0; done_dispatch = 1'b0;

        // Randomized tiles: random data, mode, completion ordering and backpressure.
        for (int t = 0; t < 8; t++) begin
            for (int n = 0; n < M*K; n++) res[n] = $urandom();
            md = 1'($urandom_range(0, 1));
            d1 = $urandom_range(0, 6);
            d2 = $urandom_range(0, 6);
            clear_got();
            bp_random = 1'b1;
            do_start(md);
            j = 0;
            while (!(done && done_dispatch)) begin
                if (j == d1) done = 1'b1;
                if (j == d2) done_dispatch = 1'b1;
                step();
                j++;
            end
            wait_done($sformatf("rand%0d", t), 300, td);
            bp_random = 1'b0;
            fifo_full = 1'b0;
            fill_exp(md);
            cmp_seq($sformatf("rand%0d", t));
            done = 1'b0; done_dispatch = 1'b0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
